tiamc1_rom_loader: RTL and testbench

- Sequences HPS ROM download into the TIA-MC1 core's shared single-port ROM memory and arbitrates that port between the download writer and CPU fetches.
- Holds the core in reset while a download is in progress and for a fixed time afterwards.
- Latches the title number from index-1 downloads.
- Sits between the HPS ioctl stream and the tiamc1 core, in the clk_sys domain.

---
 rtl/tiamc1_rom_loader.sv | 174 +++++++++++++++++
 tb/tb_tiamc1_rom_loader.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiamc1_rom_loader.sv
// TIA-MC1 ROM download sequencer and shared ROM port arbiter (clk_sys domain).
// Optional: define TIAMC1_ROM_CHECKSUM_EN to add the rom_sum download checksum output.
module tiamc1_rom_loader #(
    parameter logic [19:0] PROG_SIZE   = 20'h0E000,
    parameter logic [19:0] GFX_BASE    = 20'h10000,
    parameter logic [19:0] GFX_SIZE    = 20'h08000,
    parameter logic [15:0] HOLD_CYCLES = 16'd1024
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  dn_index,
    input  logic [19:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic        dn_wr,
    input  logic        cpu_req,
    input  logic        cpu_sel,
    input  logic [15:0] cpu_addr,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [16:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic        core_reset,
    output logic [7:0]  tno,
    output logic        bad_addr
`ifdef TIAMC1_ROM_CHECKSUM_EN
    ,
    output logic [15:0] rom_sum
`endif
);

    localparam logic [20:0] GFX_END = {1'b0, GFX_BASE} + {1'b0, GFX_SIZE};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] hold_cnt;
    logic [15:0] hold_cnt_nxt;
    logic        load_entry;
    logic        dl_q;
    logic        dl_rise;
    logic        dl_fall;

    logic        rom_wr;
    logic        in_prog;
    logic        in_gfx;
    logic        wr_accept;
    logic        wr_drop;
    logic [16:0] gfx_off;
    logic [16:0] wr_addr;

    logic        wb_valid;
    logic [16:0] wb_addr;
    logic [7:0]  wb_data;

    logic        rd_issue;
    logic        rd_p1;
    logic [16:0] rd_addr;

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            hold_cnt <= HOLD_CYCLES;
            dl_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            dl_q     <= ioctl_download;
        end
    end

    // The IDLE countdown covers the post-reset hold; HOLD covers the post-download hold.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        load_entry   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hold_cnt != 16'd0)
                    hold_cnt_nxt = hold_cnt - 16'd1;
                if (ioctl_download && dn_index == 8'd0) begin
                    state_nxt  = ST_LOAD;
                    load_entry = 1'b1;
                end
            end
            ST_LOAD: begin
                if (dl_fall) begin
                    state_nxt    = ST_HOLD;
                    hold_cnt_nxt = HOLD_CYCLES;
                end
            end
            ST_HOLD: begin
                if (dl_rise) begin
                    state_nxt    = ST_LOAD;
                    hold_cnt_nxt = HOLD_CYCLES;
                    load_entry   = 1'b1;
                end else if (hold_cnt <= 16'd1) begin
                    state_nxt    = ST_IDLE;
                    hold_cnt_nxt = 16'd0;
                end else begin
                    hold_cnt_nxt = hold_cnt - 16'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign core_reset = (state != ST_IDLE) || (hold_cnt != 16'd0);

    assign rom_wr    = dn_wr && dn_index == 8'd0;
    assign in_prog   = dn_addr < PROG_SIZE;
    assign in_gfx    = ({1'b0, dn_addr} >= {1'b0, GFX_BASE}) && ({1'b0, dn_addr} < GFX_END);
    assign wr_accept = rom_wr & (in_prog | in_gfx);
    assign wr_drop   = rom_wr & ~(in_prog | in_gfx);
    assign gfx_off   = dn_addr[16:0] - GFX_BASE[16:0] + PROG_SIZE[16:0];
    assign wr_addr   = in_prog ? dn_addr[16:0] : gfx_off;

    // A buffered write always owns the next cycle; reads wait behind any pending write.
    assign rd_issue = cpu_req & ~wb_valid & ~wr_accept & ~rd_p1 & ~cpu_ack;
    assign rd_addr  = cpu_sel ? (PROG_SIZE[16:0] + {1'b0, cpu_addr}) : {1'b0, cpu_addr};

    assign mem_we   = wb_valid;
    assign mem_din  = wb_data;
    assign mem_addr = wb_valid ? wb_addr : rd_addr;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid  <= 1'b0;
            wb_addr   <= 17'd0;
            wb_data   <= 8'd0;
            rd_p1     <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= 8'd0;
            tno       <= 8'd0;
            bad_addr  <= 1'b0;
        end else begin
            wb_valid <= wr_accept;
            if (wr_accept) begin
                wb_addr <= wr_addr;
                wb_data <= dn_data;
            end
            rd_p1   <= rd_issue;
            cpu_ack <= rd_p1;
            if (rd_p1)
                cpu_rdata <= mem_dout;
            if (dn_wr && dn_index == 8'd1)
                tno <= dn_data;
            if (load_entry)
                bad_addr <= 1'b0;
            if (wr_drop)
                bad_addr <= 1'b1;
        end
    end

`ifdef TIAMC1_ROM_CHECKSUM_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            rom_sum <= 16'd0;
        else
            rom_sum <= (load_entry ? 16'd0 : rom_sum) + (wr_accept ? {8'd0, dn_data} : 16'd0);
    end
`endif

endmodule

// File: tb/tb_tiamc1_rom_loader.sv
// Scoreboard testbench for tiamc1_rom_loader with a behavioural ROM image model.
// Checks rom_sum as well when TIAMC1_ROM_CHECKSUM_EN is defined.
module tb_tiamc1_rom_loader;

    localparam logic [19:0] PROG_SIZE = 20'h0E000;
    localparam logic [19:0] GFX_BASE  = 20'h10000;
    localparam logic [19:0] GFX_SIZE  = 20'h08000;
    localparam int          HOLD      = 1024;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  dn_index;
    logic [19:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        cpu_req;
    logic        cpu_sel;
    logic [15:0] cpu_addr;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        core_reset;
    logic [7:0]  tno;
    logic        bad_addr;
`ifdef TIAMC1_ROM_CHECKSUM_EN
    logic [15:0] rom_sum;
`endif

    always #5 clk_sys = ~clk_sys;

    tiamc1_rom_loader dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .dn_index       (dn_index),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .cpu_req        (cpu_req),
        .cpu_sel        (cpu_sel),
        .cpu_addr       (cpu_addr),
        .cpu_ack        (cpu_ack),
        .cpu_rdata      (cpu_rdata),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .core_reset     (core_reset),
        .tno            (tno),
        .bad_addr       (bad_addr)
`ifdef TIAMC1_ROM_CHECKSUM_EN
        ,
        .rom_sum        (rom_sum)
`endif
    );

    // Single-port synchronous RAM standing in for the core's ROM memory
    logic [7:0] mem [0:131071];
    always @(posedge clk_sys) begin
        if (mem_we)
            mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic        sel;
        logic [15:0] off;
    } loc_t;

    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    loc_t       written[$];
    logic [7:0] prog_img [int];
    logic [7:0] gfx_img [int];

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic        exp_bad      = 1'b0;
    logic [7:0]  exp_tno      = 8'd0;
    logic [15:0] exp_sum      = 16'd0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk_sys);
        #1;
    endtask

    // One dn_wr strobe followed by idle cycles; the reference model is updated as the byte is offered.
    task automatic applyStimulus(input logic [7:0] idx, input logic [19:0] addr,
                                 input logic [7:0] data, input int gap);
        wr_t  w;
        loc_t loc;
        int   off;
        dn_index = idx;
        dn_addr  = addr;
        dn_data  = data;
        dn_wr    = 1'b1;
        if (idx == 8'd1) begin
            exp_tno = data;
        end else if (idx == 8'd0) begin
            if (addr < PROG_SIZE) begin
                off      = int'(addr);
                w.addr   = 17'(off);
                loc.sel  = 1'b0;
                prog_img[off] = data;
            end else if (addr >= GFX_BASE && addr < GFX_BASE + GFX_SIZE) begin
                off      = int'(addr) - int'(GFX_BASE);
                w.addr   = 17'(int'(PROG_SIZE) + off);
                loc.sel  = 1'b1;
                gfx_img[off] = data;
            end else begin
                off = -1;
                exp_bad = 1'b1;
            end
            if (off >= 0) begin
                w.data  = data;
                loc.off = 16'(off);
                wr_q.push_back(w);
                written.push_back(loc);
                exp_sum = exp_sum + {8'd0, data};
            end
        end
        stepCycle();
        dn_wr = 1'b0;
        repeat (gap - 1) stepCycle();
    endtask

    task automatic doRead(input logic sel, input logic [15:0] off);
        logic [7:0] exp;
        bit         got;
        exp = sel ? gfx_img[int'(off)] : prog_img[int'(off)];
        rd_q.push_back(exp);
        cpu_sel  = sel;
        cpu_addr = off;
        cpu_req  = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_sys);
            if (cpu_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checkOutput("read_timeout", 32'd0, 32'd1);
            rd_q.delete();
        end
        stepCycle();
        cpu_req = 1'b0;
    endtask

    // Counts clock edges until core_reset is seen low
    task automatic waitCoreResetLow(input string name, input int exp_edges);
        int n;
        bit done;
        n = 0;
        done = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk_sys);
            n++;
            @(negedge clk_sys);
            if (!core_reset) begin
                done = 1;
                break;
            end
        end
        if (!done)
            checkOutput({name, "_timeout"}, 32'd0, 32'd1);
        else
            checkOutput(name, n, exp_edges);
        stepCycle();
    endtask

    task automatic drainQueues();
        for (int k = 0; k < 64; k++) begin
            if (wr_q.size() == 0 && rd_q.size() == 0)
                break;
            stepCycle();
        end
        checkOutput("queue_drain", wr_q.size() + rd_q.size(), 32'd0);
    endtask

    // Monitor: every memory write and every read acknowledge is matched against the scoreboard
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    checkOutput("spurious_mem_we", {15'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    checkOutput("mem_addr", {15'd0, mem_addr}, {15'd0, e.addr});
                    checkOutput("mem_din", {24'd0, mem_din}, {24'd0, e.data});
                end
            end
            if (cpu_ack) begin
                if (rd_q.size() == 0) begin
                    checkOutput("spurious_cpu_ack", {24'd0, cpu_rdata}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] er;
                    er = rd_q.pop_front();
                    checkOutput("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, er});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit saw_ack;
        int pick;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        dn_index       = 8'd0;
        dn_addr        = 20'd0;
        dn_data        = 8'd0;
        dn_wr          = 1'b0;
        cpu_req        = 1'b0;
        cpu_sel        = 1'b0;
        cpu_addr       = 16'd0;

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        checkOutput("reset_core_reset", {31'd0, core_reset}, 32'd1);
        checkOutput("reset_tno", {24'd0, tno}, 32'd0);
        checkOutput("reset_bad_addr", {31'd0, bad_addr}, 32'd0);
        checkOutput("reset_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        checkOutput("reset_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("reset_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        stepCycle();
        reset_n = 1'b1;
        waitCoreResetLow("startup_hold", HOLD);
        checkOutput("idle_tno", {24'd0, tno}, 32'd0);
        checkOutput("idle_bad_addr", {31'd0, bad_addr}, 32'd0);

        // First download: one program byte, one graphics byte
        dn_index = 8'd0;
        ioctl_download = 1'b1;
        stepCycle();
        @(negedge clk_sys);
        checkOutput("load_core_reset", {31'd0, core_reset}, 32'd1);
        stepCycle();
        applyStimulus(8'd0, 20'h00010, 8'hA5, 2);
        applyStimulus(8'd0, 20'h10004, 8'h3C, 2);
        drainQueues();

        // Read request coincides with a write strobe: write goes first
        cpu_sel  = 1'b1;
        cpu_addr = 16'h0004;
        cpu_req  = 1'b1;
        rd_q.push_back(gfx_img[4]);
        applyStimulus(8'd0, 20'h00020, 8'h5A, 1);
        @(negedge clk_sys);
        checkOutput("simul_write_first", {14'd0, mem_we, mem_addr}, {14'd0, 1'b1, 17'h00020});
        stepCycle();
        @(negedge clk_sys);
        checkOutput("simul_read_addr", {14'd0, mem_we, mem_addr}, {14'd0, 1'b0, 17'h0E004});
        stepCycle();
        @(negedge clk_sys);
        checkOutput("simul_ack_early", {31'd0, cpu_ack}, 32'd0);
        stepCycle();
        @(negedge clk_sys);
        checkOutput("simul_ack", {31'd0, cpu_ack}, 32'd1);
        checkOutput("simul_rdata", {24'd0, cpu_rdata}, 32'h3C);
        stepCycle();
        cpu_req = 1'b0;

        // Out-of-region byte is dropped and flagged
        applyStimulus(8'd0, 20'h0F000, 8'h11, 2);
        drainQueues();
        checkOutput("bad_addr_set", {31'd0, bad_addr}, {31'd0, exp_bad});

        ioctl_download = 1'b0;
        waitCoreResetLow("download_hold", HOLD + 1);
        checkOutput("bad_addr_sticky", {31'd0, bad_addr}, 32'd1);

        // Title-number download does not touch memory or reset
        dn_index = 8'd1;
        ioctl_download = 1'b1;
        stepCycle();
        applyStimulus(8'd1, 20'd0, 8'h03, 2);
        ioctl_download = 1'b0;
        stepCycle();
        @(negedge clk_sys);
        checkOutput("tno_loaded", {24'd0, tno}, 32'h03);
        checkOutput("title_no_reset", {31'd0, core_reset}, 32'd0);
        stepCycle();

        // Second download clears bad_addr, then checksum bytes and random traffic
        dn_index = 8'd0;
        ioctl_download = 1'b1;
        stepCycle();
        @(negedge clk_sys);
        exp_bad = 1'b0;
        exp_sum = 16'd0;
        checkOutput("bad_addr_cleared", {31'd0, bad_addr}, 32'd0);
`ifdef TIAMC1_ROM_CHECKSUM_EN
        checkOutput("rom_sum_cleared", {16'd0, rom_sum}, 32'd0);
`endif
        stepCycle();
        applyStimulus(8'd0, 20'h00100, 8'hFF, 2);
        applyStimulus(8'd0, 20'h10100, 8'h02, 2);
        applyStimulus(8'd0, 20'h0E800, 8'h10, 2);
`ifdef TIAMC1_ROM_CHECKSUM_EN
        @(negedge clk_sys);
        checkOutput("rom_sum_directed", {16'd0, rom_sum}, 32'h0101);
        stepCycle();
`endif
        for (int i = 0; i < 60; i++) begin
            int         r;
            logic [19:0] a;
            r = $urandom_range(0, 9);
            if (r < 4)
                applyStimulus(8'd0, 20'($urandom_range(0, 32'h0DFFF)), 8'($urandom), $urandom_range(2, 4));
            else if (r < 8)
                applyStimulus(8'd0, 20'($urandom_range(32'h10000, 32'h17FFF)), 8'($urandom), $urandom_range(2, 4));
            else if (r == 8) begin
                a = ($urandom_range(0, 1) == 0) ? 20'($urandom_range(32'h0E000, 32'h0FFFF))
                                                : 20'($urandom_range(32'h18000, 32'hFFFFF));
                applyStimulus(8'd0, a, 8'($urandom), $urandom_range(2, 4));
            end else
                applyStimulus(8'd1, 20'd0, 8'($urandom), $urandom_range(2, 4));
        end
        dn_index = 8'd0;
        drainQueues();
        @(negedge clk_sys);
        checkOutput("random_tno", {24'd0, tno}, {24'd0, exp_tno});
        checkOutput("random_bad_addr", {31'd0, bad_addr}, {31'd0, exp_bad});
`ifdef TIAMC1_ROM_CHECKSUM_EN
        checkOutput("random_rom_sum", {16'd0, rom_sum}, {16'd0, exp_sum});
`endif
        stepCycle();
        ioctl_download = 1'b0;
        waitCoreResetLow("download2_hold", HOLD + 1);

        // Random CPU reads of bytes the model knows about
        for (int i = 0; i < 30; i++) begin
            pick = $urandom_range(0, written.size() - 1);
            doRead(written[pick].sel, written[pick].off);
            repeat ($urandom_range(0, 2)) stepCycle();
        end
        drainQueues();

        // Reset during an in-flight read: no acknowledge may follow
        cpu_sel  = written[0].sel;
        cpu_addr = written[0].off;
        cpu_req  = 1'b1;
        stepCycle();
        reset_n = 1'b0;
        cpu_req = 1'b0;
        saw_ack = 0;
        repeat (3) begin
            @(negedge clk_sys);
            if (cpu_ack) saw_ack = 1;
        end
        stepCycle();
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk_sys);
            if (cpu_ack) saw_ack = 1;
        end
        checkOutput("reset_mid_read_no_ack", {31'd0, saw_ack}, 32'd0);
        checkOutput("reset_mid_read_core_reset", {31'd0, core_reset}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
